// File: rtl/maple_tx.sv
// Maple bus line transmitter: start pattern, two-phase bit encoding, end pattern.
// Optional trailing XOR check byte when MAPLE_TX_CRC_EN is defined.
module maple_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic       sdcka_out,
    output logic       sdckb_out,
    output logic       sdck_oe,
    output logic       busy,
    output logic       underrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_END
    } state_t;

    state_t     r_state, w_state;
    logic [3:0] r_cnt, w_cnt;
    logic [2:0] r_bit, w_bit;
    logic [1:0] r_ph, w_ph;
    logic [7:0] r_sr, w_sr;
    logic       r_last, w_last;
    logic       r_a, w_a;
    logic       r_b, w_b;
    logic       r_und, w_und;
    logic       w_bnd;
    logic       w_dbit;
    logic       w_more;
`ifdef MAPLE_TX_CRC_EN
    logic [7:0] r_crc, w_crc;
    logic       r_crcph, w_crcph;
`endif

    assign w_bnd  = (r_state == S_DATA) && (r_bit == 3'd7) && (r_ph == 2'd2);
    assign w_dbit = r_sr[3'd7 - r_bit];
`ifdef MAPLE_TX_CRC_EN
    assign w_more = ~r_last & ~r_crcph;
`else
    assign w_more = ~r_last;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_bit   <= 3'd0;
            r_ph    <= 2'd0;
            r_sr    <= 8'd0;
            r_last  <= 1'b0;
            r_a     <= 1'b1;
            r_b     <= 1'b1;
            r_und   <= 1'b0;
`ifdef MAPLE_TX_CRC_EN
            r_crc   <= 8'd0;
            r_crcph <= 1'b0;
`endif
        end else begin
            r_und <= 1'b0;
            if (tick) begin
                r_state <= w_state;
                r_cnt   <= w_cnt;
                r_bit   <= w_bit;
                r_ph    <= w_ph;
                r_sr    <= w_sr;
                r_last  <= w_last;
                r_a     <= w_a;
                r_b     <= w_b;
                r_und   <= w_und;
`ifdef MAPLE_TX_CRC_EN
                r_crc   <= w_crc;
                r_crcph <= w_crcph;
`endif
            end
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_bit   = r_bit;
        w_ph    = r_ph;
        w_sr    = r_sr;
        w_last  = r_last;
        w_a     = r_a;
        w_b     = r_b;
        w_und   = 1'b0;
`ifdef MAPLE_TX_CRC_EN
        w_crc   = r_crc;
        w_crcph = r_crcph;
`endif
        unique case (r_state)
            S_IDLE: begin
                w_a = 1'b1;
                w_b = 1'b1;
                if (in_valid) begin
                    w_state = S_START;
                    w_cnt   = 4'd0;
                    w_sr    = in_data;
                    w_last  = in_last;
`ifdef MAPLE_TX_CRC_EN
                    w_crc   = r_crc ^ in_data;
`endif
                end
            end
            S_START: begin
                w_cnt = r_cnt + 4'd1;
                if (r_cnt == 4'd0) begin
                    w_a = 1'b0;
                end else if (r_cnt == 4'd9) begin
                    w_a     = 1'b1;
                    w_state = S_DATA;
                    w_bit   = 3'd0;
                    w_ph    = 2'd0;
                end else begin
                    w_b = ~r_cnt[0];
                end
            end
            S_DATA: begin
                // even bits clock on A and carry data on B; odd bits swap
                if (r_ph == 2'd0) begin
                    if (r_bit[0]) w_a = w_dbit;
                    else          w_b = w_dbit;
                end else if (r_bit[0]) begin
                    w_b = r_ph[1];
                end else begin
                    w_a = r_ph[1];
                end
                if (r_ph == 2'd2) begin
                    w_ph  = 2'd0;
                    w_bit = r_bit + 3'd1;
                end else begin
                    w_ph = r_ph + 2'd1;
                end
                if (w_bnd) begin
                    if (w_more) begin
                        if (in_valid) begin
                            w_sr   = in_data;
                            w_last = in_last;
`ifdef MAPLE_TX_CRC_EN
                            w_crc  = r_crc ^ in_data;
`endif
                        end else begin
                            w_und   = 1'b1;
                            w_state = S_END;
                            w_cnt   = 4'd0;
                        end
`ifdef MAPLE_TX_CRC_EN
                    end else if (!r_crcph) begin
                        w_sr    = r_crc;
                        w_crcph = 1'b1;
`endif
                    end else begin
                        w_state = S_END;
                        w_cnt   = 4'd0;
                    end
                end
            end
            S_END: begin
                w_cnt = r_cnt + 4'd1;
                case (r_cnt)
                    4'd0:    w_a = 1'b1;
                    4'd1:    w_b = 1'b0;
                    4'd2:    w_a = 1'b0;
                    4'd3:    w_a = 1'b1;
                    4'd4:    w_a = 1'b0;
                    4'd5:    w_a = 1'b1;
                    4'd6:    w_b = 1'b1;
                    default: begin
                        w_state = S_IDLE;
                        w_a     = 1'b1;
                        w_b     = 1'b1;
                        w_cnt   = 4'd0;
`ifdef MAPLE_TX_CRC_EN
                        w_crc   = 8'd0;
                        w_crcph = 1'b0;
`endif
                    end
                endcase
            end
        endcase
    end

    always_comb begin
        sdcka_out = r_a;
        sdckb_out = r_b;
        sdck_oe   = (r_state != S_IDLE);
        busy      = (r_state != S_IDLE);
        underrun  = r_und;
        in_ready  = tick & ~rst & ((r_state == S_IDLE) | (w_bnd & w_more));
    end

endmodule

// File: tb/tb_maple_tx.sv
// Testbench for maple_tx: per-tick line pattern model built from frame rules.
// Works with or without MAPLE_TX_CRC_EN defined.
module tb_maple_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic       sdcka_out;
    logic       sdckb_out;
    logic       sdck_oe;
    logic       busy;
    logic       underrun;

    int checks = 0;
    int failures = 0;

`ifdef MAPLE_TX_CRC_EN
    localparam int CRCB = 1;
`else
    localparam int CRCB = 0;
`endif

    // expected {A,B,oe,busy} after each tick, plus ready/underrun per tick
    logic [3:0] exp_q[$];
    bit         rdy_q[$];
    bit         und_q[$];
    logic [7:0] dq[$];
    bit         lq[$];
    logic [7:0] pl[$];

    maple_tx dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .sdcka_out(sdcka_out),
        .sdckb_out(sdckb_out),
        .sdck_oe  (sdck_oe),
        .busy     (busy),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    function automatic void put(logic a, logic b);
        exp_q.push_back({a, b, 2'b11});
        rdy_q.push_back(1'b0);
        und_q.push_back(1'b0);
    endfunction

    task automatic clear_model();
        exp_q.delete();
        rdy_q.delete();
        und_q.delete();
        dq.delete();
        lq.delete();
    endtask

    task automatic add_frame(input logic [7:0] b[$], input bit und);
        logic [7:0] tx[$];
        logic [7:0] crc;
        logic       a, bb, v;
        int         base, n;
        n    = b.size();
        base = exp_q.size();
        crc  = 8'd0;
        tx   = b;
        foreach (b[i]) crc = crc ^ b[i];
        if (CRCB == 1 && !und) tx.push_back(crc);
        for (int i = 0; i < n; i++) begin
            dq.push_back(b[i]);
            lq.push_back((i == n - 1) ? !und : 1'b0);
        end
        a = 1'b1; bb = 1'b1;
        put(a, bb);
        a = 1'b0; put(a, bb);
        for (int i = 0; i < 8; i++) begin
            bb = i[0];
            put(a, bb);
        end
        a = 1'b1; put(a, bb);
        foreach (tx[j]) begin
            for (int k = 0; k < 8; k++) begin
                v = tx[j][7-k];
                if (k % 2 == 0) begin
                    bb = v; put(a, bb);
                    a = 1'b0; put(a, bb);
                    a = 1'b1; put(a, bb);
                end else begin
                    a = v; put(a, bb);
                    bb = 1'b0; put(a, bb);
                    bb = 1'b1; put(a, bb);
                end
            end
        end
        a = 1'b1; put(a, bb);
        bb = 1'b0; put(a, bb);
        a = 1'b0; put(a, bb);
        a = 1'b1; put(a, bb);
        a = 1'b0; put(a, bb);
        a = 1'b1; put(a, bb);
        bb = 1'b1; put(a, bb);
        exp_q.push_back(4'b1100);
        rdy_q.push_back(1'b0);
        und_q.push_back(1'b0);
        rdy_q[base] = 1'b1;
        for (int j = 0; j < n; j++)
            if (j < n - 1 || und) rdy_q[base + 10 + 24 * (j + 1)] = 1'b1;
        if (und) und_q[base + 10 + 24 * n] = 1'b1;
    endtask

    task automatic run(input int div, input int maxt,
                       output int nrdy, output int nbusy, output int nund);
        int         idx, nt;
        logic [3:0] prev, expv, obs;
        bit         hs, er, eu;
        idx = 0; nrdy = 0; nbusy = 0; nund = 0;
        prev = 4'b1100;
        nt = exp_q.size();
        if (maxt < nt) nt = maxt;
        for (int t = 0; t < nt; t++) begin
            for (int c = 0; c < div; c++) begin
                tick = (c == div - 1);
                if (idx < dq.size()) begin
                    in_valid = 1'b1;
                    in_data  = dq[idx];
                    in_last  = lq[idx];
                end else begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                    in_last  = 1'($urandom);
                end
                #1;
                er = tick && rdy_q[t];
                checks++;
                if (in_ready !== er) begin
                    failures++;
                    $display("FAIL in_ready t=%0d c=%0d got=%b exp=%b", t, c, in_ready, er);
                end
                nrdy += int'(in_ready);
                hs = in_valid && in_ready;
                @(posedge clk);
                if (hs) idx++;
                #1;
                expv = tick ? exp_q[t] : prev;
                obs  = {sdcka_out, sdckb_out, sdck_oe, busy};
                checks++;
                if (obs !== expv) begin
                    failures++;
                    $display("FAIL lines t=%0d c=%0d got=%b exp=%b", t, c, obs, expv);
                end
                eu = tick && und_q[t];
                checks++;
                if (underrun !== eu) begin
                    failures++;
                    $display("FAIL underrun t=%0d c=%0d got=%b exp=%b", t, c, underrun, eu);
                end
                nbusy += int'(busy);
                nund  += int'(underrun);
                if (tick) prev = exp_q[t];
            end
        end
        tick = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick = 1'b1; in_valid = 1'b1; in_data = 8'($urandom); in_last = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL reset_ready got=%b exp=0", in_ready);
            end
            @(posedge clk); #1;
            checks++;
            if ({sdcka_out, sdckb_out, sdck_oe, busy, underrun} !== 5'b11000) begin
                failures++;
                $display("FAIL reset_state got=%b exp=11000",
                         {sdcka_out, sdckb_out, sdck_oe, busy, underrun});
            end
        end
        rst = 1'b0; tick = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int r, b, u;
        clear_model();
        pl.delete(); pl.push_back(8'hA5);
        add_frame(pl, 1'b0);
        run(1, 1000, r, b, u);
        checks++;
        if (b != 42 + 24 * CRCB) begin
            failures++;
            $display("FAIL single_busy got=%0d exp=%0d", b, 42 + 24 * CRCB);
        end
    endtask

    task automatic test_multi();
        int r, b, u;
        clear_model();
        pl.delete(); pl.push_back(8'h3C); pl.push_back(8'h0F);
        add_frame(pl, 1'b0);
        run(1, 1000, r, b, u);
        checks++;
        if (b != 66 + 24 * CRCB || r != 2) begin
            failures++;
            $display("FAIL multi_len got=%0d/%0d exp=%0d/2", b, r, 66 + 24 * CRCB);
        end
    endtask

    task automatic test_divider();
        int r, b, u;
        clear_model();
        pl.delete(); pl.push_back(8'hFF);
        add_frame(pl, 1'b0);
        run(4, 1000, r, b, u);
        checks++;
        if (b != 4 * (42 + 24 * CRCB)) begin
            failures++;
            $display("FAIL divider_busy got=%0d exp=%0d", b, 4 * (42 + 24 * CRCB));
        end
    endtask

    task automatic test_underrun();
        int r, b, u;
        clear_model();
        pl.delete(); pl.push_back(8'h12);
        add_frame(pl, 1'b1);
        run(1, 1000, r, b, u);
        checks++;
        if (u != 1 || b != 42) begin
            failures++;
            $display("FAIL underrun_frame got=%0d/%0d exp=1/42", u, b);
        end
    endtask

    task automatic test_reset_mid();
        int r, b, u;
        clear_model();
        pl.delete(); pl.push_back(8'($urandom)); pl.push_back(8'($urandom));
        add_frame(pl, 1'b0);
        run(1, 22, r, b, u);
        rst = 1'b1; tick = 1'b1; in_valid = 1'b1; in_last = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL midrst_ready got=%b exp=0", in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if ({sdcka_out, sdckb_out, sdck_oe, busy, underrun} !== 5'b11000) begin
            failures++;
            $display("FAIL midrst_state got=%b exp=11000",
                     {sdcka_out, sdckb_out, sdck_oe, busy, underrun});
        end
        rst = 1'b0; tick = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        clear_model();
        pl.delete(); pl.push_back(8'h5A); pl.push_back(8'hC3);
        add_frame(pl, 1'b0);
        run(1, 1000, r, b, u);
    endtask

    task automatic test_back_to_back();
        int r, b, u;
        clear_model();
        pl.delete(); pl.push_back(8'($urandom));
        add_frame(pl, 1'b0);
        pl.delete(); pl.push_back(8'($urandom));
        add_frame(pl, 1'b0);
        run(1, 1000, r, b, u);
        checks++;
        if (r != 2) begin
            failures++;
            $display("FAIL b2b_ready got=%0d exp=2", r);
        end
    endtask

    task automatic test_random();
        int r, b, u, n, div;
        bit und;
        for (int f = 0; f < 6; f++) begin
            clear_model();
            pl.delete();
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
            und = ($urandom_range(0, 3) == 0);
            div = $urandom_range(1, 3);
            add_frame(pl, und);
            run(div, 1000, r, b, u);
            checks++;
            if (u != int'(und)) begin
                failures++;
                $display("FAIL rand_und f=%0d got=%0d exp=%0d", f, u, und);
            end
        end
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; in_valid = 1'b0; in_data = 8'd0; in_last = 1'b0;
        test_reset();
        test_single();
        test_multi();
        test_divider();
        test_underrun();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
